// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through an external
// 4-bit fast-adder slice; the inter-nibble carry is held in a register.
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c0,
  input  logic [3:0]       add_s,
  input  logic             add_c4
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Slice inputs come straight from registers so the external adder sees a
  // full clock period; in IDLE they are forced low.
  assign add_a  = (state_q == RUN) ? a_sh_q[3:0] : 4'h0;
  assign add_b  = (state_q == RUN) ? b_sh_q[3:0] : 4'h0;
  assign add_c0 = (state_q == RUN) ? carry_q     : 1'b0;

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so cin is ignored when sub is set.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_sh_d  = {add_s, r_sh_q[WIDTH-1:4]};
        a_sh_d  = {4'h0, a_sh_q[WIDTH-1:4]};
        b_sh_d  = {4'h0, b_sh_q[WIDTH-1:4]};
        carry_d = add_c4;
        k_d     = k_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          // Carry into the MSB is recovered from the top-nibble sum bit.
          sum_d   = {add_s, r_sh_q[WIDTH-1:4]};
          cout_d  = add_c4;
          ovf_d   = (add_a[3] ^ add_b[3] ^ add_s[3]) ^ add_c4;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: all datapath registers, including the shift registers, are
      // cleared because a reset mid-operation must abort and zero the result.
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: table vectors, hand-built
// multi-cycle sequences, and random operations against an arithmetic model.
module tb_nibble_serial_adder;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;
  logic [3:0]       add_a, add_b, add_s;
  logic             add_c0, add_c4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behaves as the external combinational 4-bit slice.
  assign {add_c4, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_c0};

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sub    (sub),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_c0 (add_c0),
    .add_s  (add_s),
    .add_c4 (add_c4)
  );

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word arithmetic: a - b is a + ~b + 1; overflow when both addends
  // share a sign that the result does not.
  function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mcin, input logic msub);
    res_t             r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb     = msub ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (ma[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != ma[WIDTH-1]);
    return r;
  endfunction

  // Called at a negedge with busy=0; returns at the negedge where done=1,
  // lat = edges from the start edge to done, -1 on timeout.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tcin, input logic tsub, output int lat);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    lat = -1;
    for (int cyc = 1; cyc <= 3 * N; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = cyc - 1;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    int   pulses;
    res_t r;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;

    tbl[0] = '{"add_wrap",     32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{"add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{"sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{"sub_cin_ign",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[4] = '{"sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{"sub_zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{"add_all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout_ovf", {cout, ovf}, 0);
    check("rst_slice_in", {add_a, add_b, add_c0}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back on each done cycle.
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat);
      check({tbl[i].name, "_lat"}, lat, N);
      check({tbl[i].name, "_sum"}, sum, tbl[i].sum);
      check({tbl[i].name, "_cout"}, cout, tbl[i].cout);
      check({tbl[i].name, "_ovf"}, ovf, tbl[i].ovf);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_slice_zero", {add_a, add_b, add_c0}, 0);

    // Carry ripples from nibble 0 into nibble 1.
    a = 32'h0000_000F; b = '0; cin = 1'b1; sub = 1'b0; start = 1'b1;
    lat = -1;
    for (int cyc = 1; cyc <= 3 * N; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        check("cin_n0_c0", add_c0, 1);
        check("cin_n0_a", add_a, 4'hF);
      end
      if (cyc == 2) check("cin_n1_c0", add_c0, 1);
      if (done) begin lat = cyc - 1; break; end
    end
    check("cin_lat", lat, N);
    check("cin_sum", sum, 32'h0000_0010);
    check("cin_cout", cout, 0);

    // Start during RUN is ignored and not queued.
    @(negedge clk);
    a = 32'h0000_1000; b = 32'h0000_0234; cin = 1'b0; sub = 1'b0; start = 1'b1;
    lat = -1;
    for (int cyc = 1; cyc <= 3 * N; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 3) begin
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; sub = 1'b1; start = 1'b1;
      end
      if (done) begin lat = cyc - 1; break; end
    end
    check("ign_lat", lat, N);
    check("ign_sum", sum, 32'h0000_1234);
    @(negedge clk);
    check("ign_no_queue", busy, 0);

    // Start on the done cycle: previous result held until the second done.
    run_op(32'h0000_00AA, 32'h0000_0011, 1'b0, 1'b0, lat);
    check("b2b_first", sum, 32'h0000_00BB);
    a = 32'h0000_0100; b = 32'h0000_0001; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_hold", sum, 32'h0000_00BB);
    lat = -1;
    for (int cyc = 2; cyc <= 3 * N; cyc++) begin
      @(negedge clk);
      if (done) begin lat = cyc - 1; break; end
      if (cyc == N) check("b2b_hold_late", sum, 32'h0000_00BB);
    end
    check("b2b_lat", lat, N);
    check("b2b_second", sum, 32'h0000_00FF);

    // Reset while nibble 3 is on the slice aborts the operation.
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_slice", {add_a, add_b, add_c0}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 2 * N; cyc++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    check("post_rst_lat", lat, N);
    check("post_rst_sum", sum, 32'h2345_6789);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) ra = {1'b0, {(WIDTH-1){1'b1}}};
      r = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, lat);
      check("rnd_lat", lat, N);
      check("rnd_sum", sum, r.sum);
      check("rnd_cout_ovf", {cout, ovf}, {r.cout, r.ovf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
